// File: rtl/sub16_serial.sv
// Bit-serial 16-bit subtractor: one bit per cycle, LSB first, registered result.
// Optional zero/neg/ovf flag outputs are enabled with SUB16_FLAGS_EN.
module sub16_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        borrow_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic        borrow_out
`ifdef SUB16_FLAGS_EN
    ,
    output logic        zero,
    output logic        neg,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] a_sh;
    logic [15:0] b_sh;
    logic [14:0] res_sh;
    logic        br;
    logic [3:0]  cnt;
    logic        d_bit;
    logic        br_nx;
    logic [15:0] res_nx;
    logic        last;

    assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nx  = (~a_sh[0] & b_sh[0])
                  | (~(a_sh[0] ^ b_sh[0]) & br);
    assign res_nx = {d_bit, res_sh};
    assign last   = (cnt == 4'd15);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= borrow_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[15:1]};
            b_sh   <= {1'b0, b_sh[15:1]};
            res_sh <= res_nx[15:1];
            br     <= br_nx;
            cnt    <= cnt + 4'd1;
            if (last) begin
                diff       <= res_nx;
                borrow_out <= br_nx;
            end
        end
    end

`ifdef SUB16_FLAGS_EN
    // Operand sign bits are shifted out during RUN, so keep copies for ovf.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_msb <= a[15];
            b_msb <= b[15];
        end else if (state == RUN && last) begin
            zero <= (res_nx == 16'h0000);
            neg  <= res_nx[15];
            ovf  <= (a_msb != b_msb) && (res_nx[15] != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_sub16_serial.sv
// Directed-vector bench for sub16_serial.
// Define SUB16_FLAGS_EN to also check the zero/neg/ovf flags.
module tb_sub16_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow_out;
`ifdef SUB16_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_both = 0;

    sub16_serial dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB16_FLAGS_EN
        ,
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) n_done++;
        if (done && busy) n_both++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] av,
                            input logic [15:0] bv,
                            input logic bin);
        @(negedge clk);
        a = av;
        b = bv;
        borrow_in = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        n;
        logic        o;
    } vec_t;

    vec_t vecs[7] = '{
        '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0},
        '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1},
        '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1},
        '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1}
    };

    initial begin
        int lat;
        int d0;
        int t1;
        int t2;
        int t;

        // Reset with start asserted: start must be ignored.
        rst = 1'b1;
        start = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        borrow_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {16'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, borrow_out}, 32'd0);
`ifdef SUB16_FLAGS_EN
        check("rst_flags", {29'd0, zero, neg, ovf}, 32'd0);
`endif
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Directed vectors with latency checks.
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), lat, 32'd16);
            check($sformatf("v%0d_diff", i), {16'd0, diff},
                  {16'd0, vecs[i].d});
            check($sformatf("v%0d_bout", i), {31'd0, borrow_out},
                  {31'd0, vecs[i].bo});
`ifdef SUB16_FLAGS_EN
            check($sformatf("v%0d_flags", i), {29'd0, zero, neg, ovf},
                  {29'd0, vecs[i].z, vecs[i].n, vecs[i].o});
`endif
            @(negedge clk);
            check($sformatf("v%0d_hold", i), {16'd0, diff},
                  {16'd0, vecs[i].d});
        end

        // Start held high: back-to-back ops 18 cycles apart.
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        borrow_in = 1'b1;
        start = 1'b1;
        t1 = -1;
        t2 = -1;
        t = 0;
        while (t < 60 && t2 < 0) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (t1 < 0) begin
                    t1 = t;
                    check("b2b_diff", {16'd0, diff}, 32'h0000FFFF);
                    check("b2b_bout", {31'd0, borrow_out}, 32'd1);
                end else begin
                    t2 = t;
                end
            end
        end
        start = 1'b0;
        check("b2b_gap", t2 - t1, 32'd18);
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        d0 = n_done;
        start_op(16'h1234, 16'h0001, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_diff", {16'd0, diff}, 32'd0);
        check("mid_rst_bout", {31'd0, borrow_out}, 32'd0);
        // Start on the very first cycle after release.
        rst = 1'b0;
        a = 16'h1234;
        b = 16'h0001;
        borrow_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("post_rst_lat", lat, 32'd16);
        check("post_rst_diff", {16'd0, diff}, 32'h00001233);
        repeat (2) @(negedge clk);
        check("post_rst_ndone", n_done - d0, 32'd1);

        // Input changes and start pulses during RUN are ignored.
        d0 = n_done;
        start_op(16'h0005, 16'h0003, 1'b0);
        repeat (3) @(negedge clk);
        a = 16'hFFFF;
        b = 16'h1234;
        borrow_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_hold_diff", {16'd0, diff}, 32'h00001233);
        check("run_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("ign_diff", {16'd0, diff}, 32'h00000002);
        check("ign_bout", {31'd0, borrow_out}, 32'd0);
        repeat (20) @(negedge clk);
        check("ign_ndone", n_done - d0, 32'd1);
        check("ign_idle", {31'd0, busy}, 32'd0);

        check("busy_done_excl", n_both, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be as listed in REQ-002..REQ-012.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  16  minuend, captured when start is accepted.
REQ-006 b  input  16  subtrahend, captured when start is accepted.
REQ-007 borrow_in  input  1  initial borrow, captured when start is accepted.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  16  registered result a - b - borrow_in (mod 2^16).
REQ-011 borrow_out  output  1  borrow out of bit 15.
REQ-012 zero, neg, ovf  output  1 each  result flags; present only with SUB16_FLAGS_EN (REQ-030).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b, borrow_in into internal shift/borrow registers, clear the 4-bit bit counter, and enter RUN.
REQ-015 RUN: each cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br); d shifts into the result shift register from the MSB side.
REQ-016 RUN SHALL last exactly 16 cycles; on the edge completing bit 15, the FSM SHALL enter DONE, load diff from the shift register and borrow_out from br'.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge N -> busy=1 after edges N+1..N+16 (16 cycles) -> done=1 in the cycle after edge N+16.
REQ-019 diff and borrow_out SHALL hold the previous result during RUN and change only at entry to DONE; they SHALL hold until the next completion.
REQ-020 start asserted in RUN or DONE SHALL be ignored (not queued); a, b, borrow_in changes after acceptance SHALL not affect the result.
REQ-021 start held continuously SHALL start a new operation on the first IDLE cycle after DONE (back-to-back period 18 cycles).
REQ-022 Result SHALL equal {borrow_out, diff} = {1'b0, a} - {1'b0, b} - borrow_in, taken as two's complement 17-bit (borrow_out=1 iff a < b + borrow_in).
REQ-023 busy and done SHALL never be high simultaneously.

Reset
REQ-024 With rst=1 at an edge, state SHALL become IDLE and busy, done, diff, borrow_out (and flags if present) SHALL be 0.
REQ-025 Reset SHALL take priority over start and over any state, including mid-RUN; the partial operation SHALL be discarded, with no done pulse.
REQ-026 start asserted in the same cycle as rst SHALL be ignored.
REQ-027 The first cycle after reset release SHALL accept start.

Configuration
REQ-028 Macro SUB16_FLAGS_EN SHALL control the flag outputs.
REQ-029 Without SUB16_FLAGS_EN: ports zero, neg, ovf and their logic SHALL be absent; all other behaviour unchanged.
REQ-030 With SUB16_FLAGS_EN: zero=(diff==0), neg=diff[15], ovf=(a[15]!=b[15]) & (diff[15]!=a[15]) using captured operands; registered, updated together with diff, reset to 0.

Verification
REQ-031 a=0000, b=0000, borrow_in=0, start pulse -> done after 17 cycles; diff=0000, borrow_out=0, zero=1.
REQ-032 a=0000, b=0001, borrow_in=0 -> diff=FFFF, borrow_out=1, neg=1, ovf=0; a=0001, b=0001, borrow_in=1 -> diff=FFFF, borrow_out=1.
REQ-033 a=AAAA, b=5555, borrow_in=0 -> diff=5555, borrow_out=0, ovf=1; a=8000, b=0001 -> diff=7FFF, ovf=1.
REQ-034 a=FFFF, b=FFFF, borrow_in=1 -> diff=FFFF, borrow_out=1; repeat with start held high -> second done exactly 18 cycles after first.
REQ-035 Start a=1234, b=0001; assert rst at RUN cycle 8 -> no done, all outputs 0; next start a=1234, b=0001 -> diff=1233.
REQ-036 Start a=0005, b=0003; change a/b and pulse start during RUN -> single done, diff=0002; previous diff held during RUN.
